// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Holds the loader FSM state encoding and the default sizing constants.
package loader_pkg;

  localparam int LOADER_ADDR_WIDTH = 6;
  localparam int CHK_WIDTH         = 8;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    CHECK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a stream of bytes into little-endian 32-bit words.
// The first byte of each word lands in bits 7:0.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] low_bytes;

  // High when the byte now being offered completes the current word.
  assign last_byte = (idx == 2'd3);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      low_bytes  <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx       <= '0;
        low_bytes <= '0;
      end else if (enable) begin
        idx <= idx + 2'd1;
        case (idx)
          2'd0: low_bytes[7:0]   <= byte_in;
          2'd1: low_bytes[15:8]  <= byte_in;
          2'd2: low_bytes[23:16] <= byte_in;
          2'd3: begin
            // The output word only changes on completion, so it holds between writes.
            word       <= {byte_in, low_bytes};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: fills instruction memory from a byte stream, verifies a
// trailing checksum byte, and stalls the core while the load is in progress.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [ADDR_WIDTH:0]   target;
  logic [ADDR_WIDTH:0]   word_next;
  logic [CHK_WIDTH-1:0]  chk_acc;
  logic [CHK_WIDTH-1:0]  chk_sum;
  logic                  accept;
  logic                  count_ok;
  logic                  load_start;
  logic                  pack_en;
  logic                  pk_last;

  assign busy       = (state == RECV) || (state == CHECK);
  assign byte_ready = busy;
  assign core_hold  = busy;

  assign accept     = byte_valid && busy;
  assign count_ok   = (word_count != '0) && (word_count <= MAX_WORDS);
  assign load_start = start && !busy && count_ok;
  assign pack_en    = accept && (state == RECV);
  assign word_next  = word_idx + ONE_WORD;
  // Sized sum so the modulo-256 wrap happens before the zero test.
  assign chk_sum    = chk_acc + byte_data;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .enable     (pack_en),
    .byte_in    (byte_data),
    .last_byte  (pk_last),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_idx <= '0;
      target   <= '0;
      chk_acc  <= '0;
      wr_addr  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            if (count_ok) begin
              state    <= RECV;
              word_idx <= '0;
              target   <= word_count;
              chk_acc  <= '0;
              done     <= 1'b0;
              error    <= 1'b0;
            end else begin
              state <= ERR;
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end
        RECV: begin
          if (accept) begin
            chk_acc <= chk_sum;
            if (pk_last) begin
              wr_addr  <= word_idx[ADDR_WIDTH-1:0];
              word_idx <= word_next;
              if (word_next == target) state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            done <= 1'b1;
            if (chk_sum == '0) begin
              state <= DONE;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a transaction-level model predicts every
// output each cycle, and directed tests pin key values with literal expectations.
module tb_imem_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          core_hold;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: what the outputs must be, from the load's word list and byte count.
  logic          m_busy, m_done, m_err, m_wr;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  logic [7:0]    m_sum;
  int            m_taken, m_wc;
  logic [31:0]   m_words[$];

  int            n_writes = 0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_wr = 0;
    m_addr = '0; m_data = '0; m_sum = '0; m_taken = 0; m_wc = 0;
  endtask

  task automatic model_start(input int wc);
    if (wc == 0 || wc > (1 << AW)) begin
      m_done = 1; m_err = 1;
    end else begin
      m_busy = 1; m_done = 0; m_err = 0;
      m_taken = 0; m_sum = '0; m_wc = wc;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] total;
    if (m_taken < 4 * m_wc) begin
      m_sum = m_sum + b;
      if (m_taken % 4 == 3) begin
        m_wr   = 1;
        m_addr = AW'(m_taken / 4);
        m_data = m_words[m_taken / 4];
      end
    end else begin
      total  = m_sum + b;
      m_busy = 0;
      m_done = 1;
      m_err  = (total != 8'h00);
    end
    m_taken++;
  endtask

  function automatic logic [7:0] chk_of();
    logic [7:0] s = 8'h00;
    foreach (m_words[i]) begin
      s = s + m_words[i][7:0];
      s = s + m_words[i][15:8];
      s = s + m_words[i][23:16];
      s = s + m_words[i][31:24];
    end
    return 8'h00 - s;
  endfunction

  // One clock cycle of stimulus; the model advances on the same edge.
  task automatic step(input logic st, input logic v, input logic [7:0] d);
    logic pre_busy;
    int   wc;
    start      = st;
    byte_valid = v;
    byte_data  = d;
    wc         = int'(word_count);
    @(posedge clk);
    pre_busy = m_busy;
    m_wr     = 0;
    if (v && pre_busy) model_byte(d);
    if (st && !pre_busy) model_start(wc);
    #1;
    start      = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic load(input int wc, input int gap_every, input bit corrupt, input int pulse_at);
    logic [31:0] w;
    logic [7:0]  b;
    word_count = AW'(0) + (AW+1)'(wc);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4 * wc; i++) begin
      w = m_words[i / 4];
      b = w[8 * (i % 4) +: 8];
      if (gap_every > 0 && i % gap_every == 1) step(1'b0, 1'b0, 8'h00);
      step(i == pulse_at, 1'b1, b);
    end
    step(1'b0, 1'b1, corrupt ? 8'h00 : chk_of());
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_writes++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    check("wr_en",      32'(wr_en),      32'(m_wr));
    check("wr_addr",    32'(wr_addr),    32'(m_addr));
    check("wr_data",    wr_data,         m_data);
    check("busy",       32'(busy),       32'(m_busy));
    check("core_hold",  32'(core_hold),  32'(m_busy));
    check("byte_ready", 32'(byte_ready), 32'(m_busy));
    check("done",       32'(done),       32'(m_done));
    check("error",      32'(error),      32'(m_err));
  end

  initial begin
    int w0;
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    word_count = 7'd1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_data", wr_data, 32'h0);

    // Single-word load with literal bytes and checksum.
    m_words = '{32'h00500013};
    word_count = 7'd1;
    w0 = n_writes;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h13);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h50);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h9D);
    step(1'b0, 1'b0, 8'h00);
    check("t1_writes", 32'(n_writes - w0), 32'd1);
    check("t1_addr",   32'(last_addr), 32'd0);
    check("t1_data",   last_data, 32'h00500013);
    check("t1_done",   32'(done),  32'd1);
    check("t1_error",  32'(error), 32'd0);
    check("t1_busy",   32'(busy),  32'd0);

    // Three-word load with valid gaps.
    m_words = '{32'h00500093, 32'h00a00113, 32'h002081b3};
    w0 = n_writes;
    load(3, 3, 1'b0, -1);
    check("t2_writes", 32'(n_writes - w0), 32'd3);
    check("t2_addr",   32'(last_addr), 32'd2);
    check("t2_data",   last_data, 32'h002081b3);
    check("t2_done",   32'(done),  32'd1);
    check("t2_error",  32'(error), 32'd0);

    // Bad checksum: write still happens, then error.
    m_words = '{32'h00500013};
    w0 = n_writes;
    load(1, 0, 1'b1, -1);
    check("t3_writes", 32'(n_writes - w0), 32'd1);
    check("t3_data",   last_data, 32'h00500013);
    check("t3_done",   32'(done),  32'd1);
    check("t3_error",  32'(error), 32'd1);

    // Illegal counts, each from a freshly reset loader.
    pulse_reset();
    w0 = n_writes;
    word_count = 7'd0;
    step(1'b1, 1'b0, 8'h00);
    check("t4a_done",  32'(done),  32'd1);
    check("t4a_error", 32'(error), 32'd1);
    check("t4a_busy",  32'(busy),  32'd0);
    step(1'b0, 1'b1, 8'hAA);
    step(1'b0, 1'b0, 8'h00);
    pulse_reset();
    word_count = 7'd65;
    step(1'b1, 1'b0, 8'h00);
    check("t4b_done",  32'(done),  32'd1);
    check("t4b_error", 32'(error), 32'd1);
    check("t4b_busy",  32'(busy),  32'd0);
    step(1'b0, 1'b1, 8'h55);
    step(1'b0, 1'b0, 8'h00);
    check("t4_writes", 32'(n_writes - w0), 32'd0);

    // Reset after six bytes of a two-word load, then reload from address 0.
    m_words = '{32'h11223344, 32'h55667788};
    word_count = 7'd2;
    w0 = n_writes;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h44);
    step(1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h88);
    step(1'b0, 1'b1, 8'h77);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("t5_busy",    32'(busy),       32'd0);
    check("t5_ready",   32'(byte_ready), 32'd0);
    check("t5_wr_en",   32'(wr_en),      32'd0);
    check("t5_wr_addr", 32'(wr_addr),    32'd0);
    check("t5_wr_data", wr_data,         32'h0);
    check("t5_done",    32'(done),       32'd0);
    check("t5_writes",  32'(n_writes - w0), 32'd1);
    check("t5_addr",    32'(last_addr),  32'd0);
    check("t5_data",    last_data,       32'h11223344);
    @(posedge clk);
    #1 reset = 1'b0;
    m_words = '{32'hCAFEF00D};
    load(1, 0, 1'b0, -1);
    check("t5r_addr", 32'(last_addr), 32'd0);
    check("t5r_data", last_data, 32'hCAFEF00D);
    check("t5r_done", 32'(done), 32'd1);

    // Full capacity with a start pulse mid-load.
    m_words = {};
    for (int i = 0; i < 64; i++) m_words.push_back(32'(i) * 32'h9E3779B9 + 32'h0000_0013);
    w0 = n_writes;
    load(64, 0, 1'b0, 77);
    check("t6_writes", 32'(n_writes - w0), 32'd64);
    check("t6_addr",   32'(last_addr), 32'd63);
    check("t6_done",   32'(done),  32'd1);
    check("t6_error",  32'(error), 32'd0);
    check("t6_busy",   32'(busy),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
